imm_gen_pipe: RTL
=================

# imm_gen_pipe

Pipelined, parametrised immediate generator for the decode stage. It accepts one 32-bit instruction per cycle over a valid/ready handshake and decodes the immediate and its format. Beyond plain sign-extension, it also decodes shift-amount immediates, CSR zero-extended immediates, illegal opcodes and RV64 word opcodes. Results are registered through a 2-entry skid buffer, so upstream fetch and downstream execute are fully decoupled without combinational ready paths.

## Interface
Parameters:
- XLEN, 32: datapath width, 32 or 64; immediates are sign/zero-extended to XLEN.
- TAG_W, 8: width of the sideband tag (PC index / ROB id) carried alongside each instruction.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  block can accept; registered (equals !skid_valid).
- in_instr  in  32  instruction word.
- in_tag  in  TAG_W  sideband tag, passed through unchanged.
- out_valid  out  1  decoded result valid.
- out_ready  in  1  downstream accepts.
- out_imm  out  XLEN  decoded immediate.
- out_type  out  3  0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (CSR zimm), 7 SH (shamt).
- out_illegal  out  1  opcode not recognised for this XLEN, or instr[1:0] != 2'b11.
- out_tag  out  TAG_W  tag of the output instruction.

## Operation
- Decode (combinational, on in_instr):
  - LUI/AUIPC: U; {instr[31:12],12'b0}, sign-extended from bit 31 to XLEN.
  - JAL: J; {instr[31],instr[19:12],instr[20],instr[30:21],1'b0} sign-extended.
  - JALR, LOAD, OP-IMM (non-shift), FENCE, SYSTEM funct3=000: I; instr[31:20] sign-extended.
  - STORE: S; {instr[31:25],instr[11:7]} sign-extended.
  - BRANCH: B; {instr[31],instr[7],instr[30:25],instr[11:8],1'b0} sign-extended.
  - OP-IMM funct3 001/101: SH; zero-extended shamt, instr[24:20] (XLEN=32) or instr[25:20] (XLEN=64).
  - SYSTEM funct3[2]=1: Z; zero-extended instr[19:15].
  - SYSTEM funct3=001/010/011: I (CSR address, sign-extended like I).
  - OP (R-type): NONE, imm = 0, legal.
  - OP-IMM-32 (0011011): XLEN=64 only; funct3 001/101 → SH with instr[24:20], else I. OP-32 (0111011): XLEN=64 only, NONE. With XLEN=32 both are illegal.
  - Anything else: illegal=1, type NONE, imm 0.
- No output is ever left undriven or latched; every path assigns imm, type and illegal.
- Skid buffer: main register (M) plus skid register (K), each holding {imm,type,illegal,tag} and a valid bit.
  - Accept = in_valid & in_ready. Drain = out_valid & out_ready.
  - M empty or draining: accepted data loads M, or K moves into M if K is valid (K first, preserving order).
  - M full and not draining: accepted data loads K.
  - Order is strictly FIFO; at most 2 entries held.

## Timing
- Latency: accept at edge N → out_valid high after edge N, i.e. visible in cycle N+1.
- Throughput: 1/cycle while out_ready=1.
- in_ready = !K.valid, registered; no combinational path from out_ready to in_ready.
- Output fields stay stable while out_valid=1 and out_ready=0.
- Simultaneous accept and drain with K empty: M is replaced by the new data; in_ready stays 1.
- Simultaneous accept and drain with K full: impossible (in_ready=0). Drain moves K→M and in_ready rises next cycle.
- Reset (any cycle, including mid-stall): M.valid=K.valid=0, out_valid=0, in_ready=1, out_imm=0, out_type=0, out_illegal=0, out_tag=0. In-flight entries are discarded.

## Test plan
- ADDI 0xFFF00093, out_ready=1 → next cycle out_imm=0xFFFFFFFF, type=1; LUI 0x123452B7 → 0x12345000, type=4.
- JAL 0xFFDFF06F → out_imm=0xFFFFFFFC, type=5. With XLEN=64 → 0xFFFFFFFFFFFFFFFC.
- SRAI 0x4030D093 → out_imm=3, type=7. CSRRWI 0x3002D073 → out_imm=5, type=6.
- 0x00000000 → out_illegal=1, type=0, imm=0. 0x0000001B with XLEN=32 → illegal=1; with XLEN=64 → legal, type=1.
- Hold out_ready=0 and drive 3 back-to-back valids with tags 1,2,3. Tags 1 and 2 are accepted and in_ready falls; tag 3 is held. Release out_ready: outputs come out as tags 1, 2, 3, with no loss or duplication.
- Assert rst with both entries full → next cycle out_valid=0, in_ready=1, all outputs 0; first instruction after reset is decoded correctly.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator: one instruction per cycle in, decoded immediate/format/illegal out.
// Latency 1 cycle through a 2-entry skid buffer; in_ready is registered and only drops when the skid slot is occupied.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_type,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    localparam bit IS64 = (XLEN == 64);

    localparam logic [2:0] T_NONE = 3'd0;
    localparam logic [2:0] T_I    = 3'd1;
    localparam logic [2:0] T_S    = 3'd2;
    localparam logic [2:0] T_B    = 3'd3;
    localparam logic [2:0] T_U    = 3'd4;
    localparam logic [2:0] T_J    = 3'd5;
    localparam logic [2:0] T_Z    = 3'd6;
    localparam logic [2:0] T_SH   = 3'd7;

    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_FENCE     = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [2:0]       typ;
        logic             ill;
        logic [TAG_W-1:0] tag;
    } ent_t;

    // ---------------- decode ----------------
    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic        w_is_shift;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_j;
    logic [31:0] w_imm_z;
    logic [31:0] w_shamt;
    logic [31:0] w_shamt_w;
    logic [31:0] w_imm32;
    logic [2:0]  w_type;
    logic        w_illegal;
    logic [XLEN-1:0] w_imm;
    ent_t        w_dec;

    assign w_opcode   = in_instr[6:0];
    assign w_funct3   = in_instr[14:12];
    assign w_is_shift = (w_funct3 == 3'b001) || (w_funct3 == 3'b101);

    assign w_imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
    assign w_imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign w_imm_b = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    assign w_imm_u = {in_instr[31:12], 12'b0};
    assign w_imm_j = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
    assign w_imm_z = {27'b0, in_instr[19:15]};
    // RV64 shifts carry a 6-bit shamt; the W-form shifts are always 5 bits.
    assign w_shamt   = IS64 ? {26'b0, in_instr[25:20]} : {27'b0, in_instr[24:20]};
    assign w_shamt_w = {27'b0, in_instr[24:20]};

    // All valid opcodes end in 2'b11, so compressed/garbage encodings fall into default.
    always_comb begin
        w_imm32   = '0;
        w_type    = T_NONE;
        w_illegal = 1'b0;
        case (w_opcode)
            OPC_LUI, OPC_AUIPC: begin
                w_type  = T_U;
                w_imm32 = w_imm_u;
            end
            OPC_JAL: begin
                w_type  = T_J;
                w_imm32 = w_imm_j;
            end
            OPC_JALR, OPC_LOAD, OPC_FENCE: begin
                w_type  = T_I;
                w_imm32 = w_imm_i;
            end
            OPC_STORE: begin
                w_type  = T_S;
                w_imm32 = w_imm_s;
            end
            OPC_BRANCH: begin
                w_type  = T_B;
                w_imm32 = w_imm_b;
            end
            OPC_OP_IMM: begin
                if (w_is_shift) begin
                    w_type  = T_SH;
                    w_imm32 = w_shamt;
                end else begin
                    w_type  = T_I;
                    w_imm32 = w_imm_i;
                end
            end
            OPC_SYSTEM: begin
                if (w_funct3[2]) begin
                    w_type  = T_Z;
                    w_imm32 = w_imm_z;
                end else begin
                    w_type  = T_I;
                    w_imm32 = w_imm_i;
                end
            end
            OPC_OP: begin
                w_type = T_NONE;
            end
            OPC_OP_IMM_32: begin
                if (!IS64) begin
                    w_illegal = 1'b1;
                end else if (w_is_shift) begin
                    w_type  = T_SH;
                    w_imm32 = w_shamt_w;
                end else begin
                    w_type  = T_I;
                    w_imm32 = w_imm_i;
                end
            end
            OPC_OP_32: begin
                w_illegal = !IS64;
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

    // Zero-extended forms have bit 31 clear, so one sign extension serves every format.
    generate
        if (IS64) begin : g_x64
            assign w_imm = {{32{w_imm32[31]}}, w_imm32};
        end else begin : g_x32
            assign w_imm = w_imm32;
        end
    endgenerate

    assign w_dec = '{imm: w_imm, typ: w_type, ill: w_illegal, tag: in_tag};

    // ---------------- skid buffer ----------------
    ent_t r_m;
    ent_t r_k;
    logic r_m_vld;
    logic r_k_vld;
    logic r_in_rdy;

    logic w_accept;
    logic w_drain;
    logic w_m_free;
    logic w_k_vld_nxt;

    assign w_accept    = in_valid & r_in_rdy;
    assign w_drain     = r_m_vld & out_ready;
    assign w_m_free    = ~r_m_vld | w_drain;
    assign w_k_vld_nxt = w_m_free ? 1'b0 : (r_k_vld | w_accept);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_m      <= '0;
            r_k      <= '0;
            r_m_vld  <= 1'b0;
            r_k_vld  <= 1'b0;
            r_in_rdy <= 1'b1;
        end else begin
            if (w_m_free) begin
                // The skid entry is older than anything arriving now, so it goes first.
                if (r_k_vld) begin
                    r_m     <= r_k;
                    r_m_vld <= 1'b1;
                end else if (w_accept) begin
                    r_m     <= w_dec;
                    r_m_vld <= 1'b1;
                end else begin
                    r_m_vld <= 1'b0;
                end
            end else if (w_accept) begin
                r_k <= w_dec;
            end
            r_k_vld  <= w_k_vld_nxt;
            r_in_rdy <= ~w_k_vld_nxt;
        end
    end

    assign in_ready    = r_in_rdy;
    assign out_valid   = r_m_vld;
    assign out_imm     = r_m.imm;
    assign out_type    = r_m.typ;
    assign out_illegal = r_m.ill;
    assign out_tag     = r_m.tag;

endmodule
